// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-divide controller: state encoding and divisor limits.
package clk_div_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DIV   = 20;
  localparam int unsigned MIN_DIV   = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RUN      = 2'd1;
  localparam state_t ST_STOPPING = 2'd2;

endpackage

// File: rtl/div_period_cnt.sv
// Period counter for the divided clock: position within the period, wrap flag and
// the registered high/low compare that forms the output clock.
module div_period_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] div_i,
  input  logic             count_i,
  input  logic             run_i,
  output logic             wrap_o,
  output logic             oclk_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d, next_cnt;
  logic             oclk_q, oclk_d;
  logic             wrap;

  assign wrap = (cnt_q == div_i - WIDTH'(1));

  // A fresh period (start or wrap) begins at 0; leaving the run states parks everything low.
  always_comb begin
    next_cnt = '0;
    if (count_i && !wrap) begin
      next_cnt = cnt_q + WIDTH'(1);
    end
    cnt_d  = run_i ? next_cnt : '0;
    oclk_d = run_i && (next_cnt < (div_i >> 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      oclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      oclk_q <= oclk_d;
    end
  end

  assign wrap_o = wrap;
  assign oclk_o = oclk_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller for the divided clock; new divisors are staged in a
// shadow register and only take effect on a period boundary.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             O_CLK,
  output logic             tick,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             active, wrap, cnt_run, cfg_fire, cfg_legal;

  assign active    = (state_q != ST_IDLE);
  assign cfg_fire  = cfg_valid && !pend_q;
  assign cfg_legal = (cfg_div >= WIDTH'(MIN_DIV));

  // State register
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stopping always finishes the current period before going idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (en) state_d = ST_RUN;
      ST_RUN:      if (!en) state_d = ST_STOPPING;
      ST_STOPPING: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (wrap) begin
          state_d = ST_IDLE;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs: divisor/shadow/handshake updates; accept and apply are mutually exclusive on pend_q
  always_comb begin
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    err_d    = 1'b0;
    cnt_run  = (state_d != ST_IDLE);
    if (cfg_fire) begin
      if (!cfg_legal) begin
        err_d = 1'b1;
      end else if (!active) begin
        div_d = cfg_div;
      end else begin
        shadow_d = cfg_div;
        pend_d   = 1'b1;
      end
    end
    if (active && wrap && pend_q) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      div_q    <= WIDTH'(DEFAULT_DIV);
      shadow_q <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  div_period_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk_i   (I_CLK),
    .rst_ni  (rst),
    .div_i   (div_q),
    .count_i (active),
    .run_i   (cnt_run),
    .wrap_o  (wrap),
    .oclk_o  (O_CLK)
  );

  assign cfg_ready = !pend_q;
  assign cfg_err   = err_q;
  assign tick      = active && wrap;
  assign busy      = active;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: hand-computed vector table, directed corner
// sequences and randomized traffic against a period-position reference model.
module tb_clk_div_ctrl;

  localparam int unsigned W = 16;

  logic         I_CLK = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready, cfg_err, O_CLK, tick, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 I_CLK = ~I_CLK;

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(20)) dut (
    .I_CLK     (I_CLK),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .O_CLK     (O_CLK),
    .tick      (tick),
    .busy      (busy)
  );

  // Reference model: running flag, stop request, position in period, divisor, staged divisor
  bit m_active, m_stopping, m_pend, m_err;
  int m_pos, m_d, m_shadow;

  task automatic model_reset();
    m_active = 0; m_stopping = 0; m_pend = 0; m_err = 0;
    m_pos = 0; m_d = 20; m_shadow = 0;
  endtask

  task automatic model_step();
    bit take, bad, wrap;
    int val;
    if (!rst) begin
      model_reset();
      return;
    end
    val  = int'(cfg_div);
    take = cfg_valid && !m_pend && (val >= 2);
    bad  = cfg_valid && !m_pend && (val < 2);
    wrap = m_active && (m_pos == m_d - 1);
    m_err = bad;
    if (!m_active) begin
      if (take) m_d = val;
      if (en) begin
        m_active = 1; m_stopping = 0; m_pos = 0;
      end
    end else begin
      if (wrap) begin
        m_pos = 0;
        if (m_pend) begin
          m_d = m_shadow; m_pend = 0;
        end
      end else begin
        m_pos++;
      end
      if (take) begin
        m_shadow = val; m_pend = 1;
      end
      if (!m_stopping) begin
        if (!en) m_stopping = 1;
      end else if (en) begin
        m_stopping = 0;
      end else if (wrap) begin
        m_active = 0; m_pos = 0;
      end
    end
  endtask

  task automatic check1(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check1({tag, ".oclk"},  int'(O_CLK),     int'(m_active && (m_pos < m_d / 2)));
    check1({tag, ".tick"},  int'(tick),      int'(m_active && (m_pos == m_d - 1)));
    check1({tag, ".busy"},  int'(busy),      int'(m_active));
    check1({tag, ".ready"}, int'(cfg_ready), int'(!m_pend));
    check1({tag, ".err"},   int'(cfg_err),   int'(m_err));
  endtask

  task automatic clk_cycle(input bit use_model, input string tag);
    @(posedge I_CLK);
    model_step();
    #1;
    if (use_model) check_model(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      clk_cycle(1, tag);
      n++;
    end
    check1({tag, ".idle_timeout"}, int'(busy), 0);
  endtask

  task automatic load_idle(input int d);
    cfg_valid = 1; cfg_div = W'(d);
    clk_cycle(1, "load");
    cfg_valid = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 0;
    #1;
    model_reset();
    check_model(tag);
    clk_cycle(1, tag);
    clk_cycle(1, tag);
    rst = 1;
  endtask

  typedef struct {
    bit         en;
    bit         v;
    logic [W-1:0] div;
    bit         o, t, b, r, e;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int highs, ticks, n;

    // Vectors start in IDLE with the reset divisor of 20
    tbl[0]  = '{0, 1, 16'd1, 0, 0, 0, 1, 1};
    tbl[1]  = '{0, 1, 16'd0, 0, 0, 0, 1, 1};
    tbl[2]  = '{0, 1, 16'd3, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[4]  = '{1, 0, 16'd0, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 0, 16'd0, 0, 1, 1, 1, 0};
    tbl[6]  = '{1, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[7]  = '{1, 1, 16'd1, 0, 0, 1, 1, 1};
    tbl[8]  = '{0, 0, 16'd0, 0, 1, 1, 1, 0};
    tbl[9]  = '{0, 0, 16'd0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 1, 16'd2, 0, 0, 0, 1, 0};
    tbl[11] = '{1, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[12] = '{1, 0, 16'd0, 0, 1, 1, 1, 0};
    tbl[13] = '{0, 0, 16'd0, 1, 0, 1, 1, 0};
    tbl[14] = '{0, 0, 16'd0, 0, 1, 1, 1, 0};
    tbl[15] = '{0, 0, 16'd0, 0, 0, 0, 1, 0};

    // Reset state
    model_reset();
    #2;
    check_model("reset");
    clk_cycle(1, "reset");
    clk_cycle(1, "reset");
    rst = 1;
    clk_cycle(1, "idle");

    // Default divisor 20: rise one cycle after en, 10 high / 10 low, one tick per period
    en = 1;
    clk_cycle(1, "d20");
    check1("d20.first_rise", int'(O_CLK), 1);
    highs = int'(O_CLK); ticks = int'(tick);
    for (int i = 1; i < 20; i++) begin
      clk_cycle(1, "d20");
      highs += int'(O_CLK); ticks += int'(tick);
    end
    check1("d20.high_cycles", highs, 10);
    check1("d20.ticks", ticks, 1);
    for (int i = 0; i < 25; i++) clk_cycle(1, "d20");
    en = 0;
    wait_idle("d20stop");
    clk_cycle(1, "idle");

    // Hand-computed table: config errors, D=3 and D=2 runs, stop at wrap
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; cfg_valid = tbl[i].v; cfg_div = tbl[i].div;
      clk_cycle(0, "tbl");
      check1($sformatf("tbl%0d.oclk", i),  int'(O_CLK),     int'(tbl[i].o));
      check1($sformatf("tbl%0d.tick", i),  int'(tick),      int'(tbl[i].t));
      check1($sformatf("tbl%0d.busy", i),  int'(busy),      int'(tbl[i].b));
      check1($sformatf("tbl%0d.ready", i), int'(cfg_ready), int'(tbl[i].r));
      check1($sformatf("tbl%0d.err", i),   int'(cfg_err),   int'(tbl[i].e));
    end
    cfg_valid = 0; en = 0;
    clk_cycle(1, "idle");

    // D=4 running, write 6 mid-period; a second write is held off while pending
    load_idle(4);
    en = 1;
    clk_cycle(1, "ratio");
    clk_cycle(1, "ratio");
    cfg_valid = 1; cfg_div = W'(6);
    clk_cycle(1, "ratio");
    check1("ratio.ready_low", int'(cfg_ready), 0);
    cfg_div = W'(9);
    clk_cycle(1, "ratio");
    cfg_valid = 0;
    n = 0;
    while (!tick && n < 10) begin
      clk_cycle(1, "ratio");
      n++;
    end
    check1("ratio.tick_timeout", int'(tick), 1);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      clk_cycle(1, "ratio6");
      highs += int'(O_CLK);
    end
    check1("ratio6.high_cycles", highs, 3);
    check1("ratio6.last_tick", int'(tick), 1);
    for (int i = 0; i < 14; i++) clk_cycle(1, "ratio6");
    en = 0;
    wait_idle("ratiostop");

    // D=8: drop en at cnt=2, finish period; then re-raise en during STOPPING
    load_idle(8);
    en = 1;
    for (int i = 0; i < 3; i++) clk_cycle(1, "stop8");
    en = 0;
    wait_idle("stop8");
    check1("stop8.oclk_low", int'(O_CLK), 0);
    en = 1;
    for (int i = 0; i < 3; i++) clk_cycle(1, "rerun8");
    en = 0;
    clk_cycle(1, "rerun8");
    en = 1;
    for (int i = 0; i < 20; i++) clk_cycle(1, "rerun8");

    // Reset mid-period with a pending divisor
    cfg_valid = 1; cfg_div = W'(5);
    clk_cycle(1, "prerst");
    cfg_valid = 0;
    check1("prerst.pending", int'(cfg_ready), 0);
    do_reset("midrst");
    en = 1;
    for (int i = 0; i < 45; i++) clk_cycle(1, "postrst");

    // Randomized traffic
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 7) == 0);
      n = int'($urandom_range(0, 9));
      cfg_div = (n < 2) ? W'(n) : W'($urandom_range(2, 12));
      if ($urandom_range(0, 1499) == 0) begin
        do_reset("rndrst");
      end else begin
        clk_cycle(1, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
